p2p_rx_gate_ctrl: RTL

- Per-port, packet-boundary-safe gate on the CMAC→adapter RX path inside the p2p box, in the cmac_clk domain.
- Applies the register-level block_rx request only between packets, so no truncated or partial frames ever reach the adapter.
- Counts passed, dropped and errored packets per port for the AXI-lite register block.
- RX has no tready, so blocking discards beats; it never stalls them.

---
 rtl/p2p_pkg.sv | 15 +
 rtl/p2p_rx_gate_port.sv | 97 +++++++++
 rtl/p2p_rx_gate_ctrl.sv | 57 +++++
 3 files changed

// File: rtl/p2p_pkg.sv
// Shared types and constants for the p2p box RX gate.
package p2p_pkg;

  localparam int AXIS_DATA_W = 512;
  localparam int AXIS_KEEP_W = 64;

  // IDLE_PASS/BLOCKED sit between packets; IN_PASS/DROP are mid-packet.
  typedef enum logic [1:0] {
    IDLE_PASS = 2'd0,
    IN_PASS   = 2'd1,
    BLOCKED   = 2'd2,
    DROP      = 2'd3
  } gate_state_t;

endpackage

// File: rtl/p2p_rx_gate_port.sv
// One RX lane: packet-boundary-safe gate, output register and three
// saturating packet counters.
//
// Stream semantics: the RX stream has no tready. A beat is transferred
// on every cycle with s_tvalid=1 and must be consumed in that cycle,
// either forwarded (m_tvalid=1 one cycle later) or discarded. The gate
// never stalls a beat.
module p2p_rx_gate_port
  import p2p_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   block_rx,
  input  logic                   cnt_clr,
  input  logic                   s_tvalid,
  input  logic [AXIS_DATA_W-1:0] s_tdata,
  input  logic [AXIS_KEEP_W-1:0] s_tkeep,
  input  logic                   s_tlast,
  input  logic                   s_tuser_err,
  output logic                   m_tvalid,
  output logic [AXIS_DATA_W-1:0] m_tdata,
  output logic [AXIS_KEEP_W-1:0] m_tkeep,
  output logic                   m_tlast,
  output logic                   m_tuser_err,
  output logic                   blocked,
  output logic [CNT_W-1:0]       pass_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [CNT_W-1:0]       err_cnt,
  output gate_state_t            state
);

  gate_state_t next_state;
  logic        fwd;
  logic        between;
  logic        end_fwd;
  logic        end_drop;
  logic        end_err;

  // Forward/discard decision and next state; block_rx only matters between packets.
  always_comb begin
    next_state = state;
    fwd        = 1'b0;
    between    = (state == IDLE_PASS) || (state == BLOCKED);
    if (between) begin
      if (s_tvalid) begin
        fwd = !block_rx;
        if (block_rx) next_state = s_tlast ? BLOCKED : DROP;
        else          next_state = s_tlast ? IDLE_PASS : IN_PASS;
      end else begin
        next_state = block_rx ? BLOCKED : IDLE_PASS;
      end
    end else begin
      fwd = s_tvalid && (state == IN_PASS);
      if (s_tvalid && s_tlast) next_state = block_rx ? BLOCKED : IDLE_PASS;
    end
    end_fwd  = s_tvalid && s_tlast && fwd;
    end_drop = s_tvalid && s_tlast && !fwd;
    end_err  = end_fwd && s_tuser_err;
  end

  // State, output register (zeroed when not forwarding) and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE_PASS;
      m_tvalid    <= 1'b0;
      m_tdata     <= '0;
      m_tkeep     <= '0;
      m_tlast     <= 1'b0;
      m_tuser_err <= 1'b0;
      blocked     <= 1'b0;
      pass_cnt    <= '0;
      drop_cnt    <= '0;
      err_cnt     <= '0;
    end else begin
      state       <= next_state;
      m_tvalid    <= fwd;
      m_tdata     <= fwd ? s_tdata : '0;
      m_tkeep     <= fwd ? s_tkeep : '0;
      m_tlast     <= fwd && s_tlast;
      m_tuser_err <= fwd && s_tuser_err;
      blocked     <= (next_state == BLOCKED);

      // Clear takes priority over a same-cycle increment.
      if (cnt_clr)                       pass_cnt <= '0;
      else if (end_fwd && pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);

      if (cnt_clr)                        drop_cnt <= '0;
      else if (end_drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);

      if (cnt_clr)                      err_cnt <= '0;
      else if (end_err && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/p2p_rx_gate_ctrl.sv
// Per-port RX gate between CMAC and adapter: one gate instance per lane,
// this level only slices the flattened buses.
module p2p_rx_gate_ctrl
  import p2p_pkg::*;
#(
  parameter int NUM_CMAC_PORT = 2,
  parameter int CNT_W         = 32
) (
  input  logic                                 cmac_clk,
  input  logic                                 cmac_rst,
  input  logic [NUM_CMAC_PORT-1:0]             block_rx,
  input  logic [NUM_CMAC_PORT-1:0]             cnt_clr,
  input  logic [NUM_CMAC_PORT-1:0]             s_axis_cmac_rx_tvalid,
  input  logic [AXIS_DATA_W*NUM_CMAC_PORT-1:0] s_axis_cmac_rx_tdata,
  input  logic [AXIS_KEEP_W*NUM_CMAC_PORT-1:0] s_axis_cmac_rx_tkeep,
  input  logic [NUM_CMAC_PORT-1:0]             s_axis_cmac_rx_tlast,
  input  logic [NUM_CMAC_PORT-1:0]             s_axis_cmac_rx_tuser_err,
  output logic [NUM_CMAC_PORT-1:0]             m_axis_adap_rx_322mhz_tvalid,
  output logic [AXIS_DATA_W*NUM_CMAC_PORT-1:0] m_axis_adap_rx_322mhz_tdata,
  output logic [AXIS_KEEP_W*NUM_CMAC_PORT-1:0] m_axis_adap_rx_322mhz_tkeep,
  output logic [NUM_CMAC_PORT-1:0]             m_axis_adap_rx_322mhz_tlast,
  output logic [NUM_CMAC_PORT-1:0]             m_axis_adap_rx_322mhz_tuser_err,
  output logic [NUM_CMAC_PORT-1:0]             blocked,
  output logic [CNT_W*NUM_CMAC_PORT-1:0]       pass_cnt,
  output logic [CNT_W*NUM_CMAC_PORT-1:0]       drop_cnt,
  output logic [CNT_W*NUM_CMAC_PORT-1:0]       err_cnt,
  output gate_state_t [NUM_CMAC_PORT-1:0]      dbg_state
);

  // One independent gate per CMAC lane.
  for (genvar i = 0; i < NUM_CMAC_PORT; i++) begin : g_port
    p2p_rx_gate_port #(
      .CNT_W (CNT_W)
    ) u_port (
      .clk         (cmac_clk),
      .rst         (cmac_rst),
      .block_rx    (block_rx[i]),
      .cnt_clr     (cnt_clr[i]),
      .s_tvalid    (s_axis_cmac_rx_tvalid[i]),
      .s_tdata     (s_axis_cmac_rx_tdata[i*AXIS_DATA_W +: AXIS_DATA_W]),
      .s_tkeep     (s_axis_cmac_rx_tkeep[i*AXIS_KEEP_W +: AXIS_KEEP_W]),
      .s_tlast     (s_axis_cmac_rx_tlast[i]),
      .s_tuser_err (s_axis_cmac_rx_tuser_err[i]),
      .m_tvalid    (m_axis_adap_rx_322mhz_tvalid[i]),
      .m_tdata     (m_axis_adap_rx_322mhz_tdata[i*AXIS_DATA_W +: AXIS_DATA_W]),
      .m_tkeep     (m_axis_adap_rx_322mhz_tkeep[i*AXIS_KEEP_W +: AXIS_KEEP_W]),
      .m_tlast     (m_axis_adap_rx_322mhz_tlast[i]),
      .m_tuser_err (m_axis_adap_rx_322mhz_tuser_err[i]),
      .blocked     (blocked[i]),
      .pass_cnt    (pass_cnt[i*CNT_W +: CNT_W]),
      .drop_cnt    (drop_cnt[i*CNT_W +: CNT_W]),
      .err_cnt     (err_cnt[i*CNT_W +: CNT_W]),
      .state       (dbg_state[i])
    );
  end

endmodule
